// File: rtl/sort_pkg.sv
// Shared constants and FSM encoding for the byte sorter front end.
// The pad constant is also used by the downstream serializer to strip pads via frame_len.
package sort_pkg;
  localparam int SORT_N = 6;
  localparam int SORT_W = 8;
  localparam logic [SORT_W-1:0] SORT_PAD_VALUE = '1;

  typedef logic [1:0] state_t;
  localparam state_t ST_FILL  = 2'd0;
  localparam state_t ST_PAD   = 2'd1;
  localparam state_t ST_ISSUE = 2'd2;
  localparam state_t ST_WAIT  = 2'd3;
endpackage

// File: rtl/sort_frame_packer_if.sv
// Valid/ready byte stream feeding the frame packer.
interface sort_frame_packer_if
  import sort_pkg::*;
#(
  parameter int W = SORT_W
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_last;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/sort_frame_packer.sv
// Packs a byte stream into N-slot frames, pads short frames so pads sort last,
// and issues each frame with a registered start pulse followed by a fixed gap.
module sort_frame_packer
  import sort_pkg::*;
#(
  parameter int             N         = SORT_N,
  parameter int             W         = SORT_W,
  parameter logic [W-1:0]   PAD_VALUE = {W{1'b1}},
  parameter int             GAP       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  sort_frame_packer_if.slave         s_if,
  output logic [N*W-1:0]             frame_data,
  output logic [$clog2(N+1)-1:0]     frame_len,
  output logic                       start,
  output logic [15:0]                frame_cnt,
  output logic                       overflow
);
  localparam int             IW       = $clog2(N + 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0]  FULL_LEN = IW'(N);
  localparam logic [3:0]     GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     len_q, len_d;
  logic [N*W-1:0]    buf_q, buf_d;
  logic [N*W-1:0]    frame_data_q, frame_data_d;
  logic [IW-1:0]     frame_len_q, frame_len_d;
  logic              start_q, start_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              overflow_q, overflow_d;
  logic [3:0]        gap_q, gap_d;
  logic              accept;

  assign s_if.s_ready = (state_q == ST_FILL);
  assign accept       = s_if.s_valid && s_if.s_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    buf_d        = buf_q;
    frame_data_d = frame_data_q;
    frame_len_d  = frame_len_q;
    start_d      = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    overflow_d   = overflow_q;
    gap_d        = gap_q;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          buf_d[int'(idx_q)*W +: W] = s_if.s_data;
          // Slot N-1 always closes the frame; a missing last there marks overflow.
          if (idx_q == LAST_IDX) begin
            len_d   = FULL_LEN;
            state_d = ST_ISSUE;
            if (!s_if.s_last) overflow_d = 1'b1;
          end else if (s_if.s_last) begin
            len_d   = idx_q + 1'b1;
            idx_d   = idx_q + 1'b1;
            state_d = ST_PAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PAD: begin
        buf_d[int'(idx_q)*W +: W] = PAD_VALUE;
        if (idx_q == LAST_IDX) state_d = ST_ISSUE;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_ISSUE: begin
        frame_data_d = buf_q;
        frame_len_d  = len_q;
        start_d      = 1'b1;
        frame_cnt_d  = frame_cnt_q + 16'd1;
        idx_d        = '0;
        gap_d        = GAP_LOAD;
        state_d      = (GAP == 0) ? ST_FILL : ST_WAIT;
      end
      default: begin
        if (gap_q == 4'd0) state_d = ST_FILL;
        else               gap_d   = gap_q - 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FILL;
      idx_q        <= '0;
      len_q        <= '0;
      buf_q        <= '0;
      frame_data_q <= '0;
      frame_len_q  <= '0;
      start_q      <= 1'b0;
      frame_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      buf_q        <= buf_d;
      frame_data_q <= frame_data_d;
      frame_len_q  <= frame_len_d;
      start_q      <= start_d;
      frame_cnt_q  <= frame_cnt_d;
      overflow_q   <= overflow_d;
      gap_q        <= gap_d;
    end
  end

  assign frame_data = frame_data_q;
  assign frame_len  = frame_len_q;
  assign start      = start_q;
  assign frame_cnt  = frame_cnt_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_sort_frame_packer.sv
// Scoreboard bench for sort_frame_packer: expected frames are queued by the stimulus
// and popped by a monitor on every start pulse.
module tb_sort_frame_packer;
  import sort_pkg::*;

  typedef struct {
    logic [47:0] data;
    logic [2:0]  len;
    logic [15:0] cnt;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] frame_data;
  logic [2:0]  frame_len;
  logic        start;
  logic [15:0] frame_cnt;
  logic        overflow;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   cyc       = 0;
  int   last_start_cyc = -1;
  int   prev_start_cyc = -1;
  int   acc_cyc;

  sort_frame_packer_if #(.W(8)) s_if ();

  sort_frame_packer #(.N(6), .W(8), .PAD_VALUE(8'hFF), .GAP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_if       (s_if.slave),
    .frame_data (frame_data),
    .frame_len  (frame_len),
    .start      (start),
    .frame_cnt  (frame_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [47:0] d, input logic [2:0] l, input logic [15:0] c, input logic o);
    exp_t e;
    e.data = d; e.len = l; e.cnt = c; e.ov = o;
    exp_q.push_back(e);
  endtask

  // Presents one beat starting at a negedge; returns after the accepting edge, at the next negedge.
  task automatic send_beat(input logic [7:0] d, input logic last, output int acc);
    int g = 0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    s_if.s_last  = last;
    while (!s_if.s_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check_output("accept_timeout", 64'(g), 64'd0);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic apply_stimulus(input logic [7:0] first, input int n, input int last_at);
    for (int i = 0; i < n; i++)
      send_beat(first + 8'(i), (i == last_at), acc_cyc);
  endtask

  task automatic go_idle();
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && start) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_start", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("frame_data", 64'(frame_data), 64'(e.data));
        check_output("frame_len",  64'(frame_len),  64'(e.len));
        check_output("frame_cnt",  64'(frame_cnt),  64'(e.cnt));
        check_output("overflow",   64'(overflow),   64'(e.ov));
      end
      prev_start_cyc = last_start_cyc;
      last_start_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int low_cnt;
    rst = 1'b1;
    go_idle();
    s_if.s_data = 8'h00;
    repeat (2) @(negedge clk);
    check_output("rst_frame_data", 64'(frame_data), 64'd0);
    check_output("rst_frame_len",  64'(frame_len),  64'd0);
    check_output("rst_start",      64'(start),      64'd0);
    check_output("rst_frame_cnt",  64'(frame_cnt),  64'd0);
    check_output("rst_overflow",   64'(overflow),   64'd0);
    check_output("rst_s_ready",    64'(s_if.s_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Full frame 5,3,9,1,7,2
    push_exp(48'h02_07_01_09_03_05, 3'd6, 16'd1, 1'b0);
    send_beat(8'd5, 1'b0, acc_cyc);
    send_beat(8'd3, 1'b0, acc_cyc);
    send_beat(8'd9, 1'b0, acc_cyc);
    send_beat(8'd1, 1'b0, acc_cyc);
    send_beat(8'd7, 1'b0, acc_cyc);
    send_beat(8'd2, 1'b1, acc_cyc);
    go_idle();
    low_cnt = 0;
    while (!s_if.s_ready && low_cnt < 20) begin
      low_cnt++;
      @(negedge clk);
    end
    check_output("ready_low_cycles", 64'(low_cnt), 64'd3);
    check_output("full_start_latency", 64'(last_start_cyc - acc_cyc), 64'd1);
    wait_idle();

    // Short frame 4,8
    push_exp(48'hFF_FF_FF_FF_08_04, 3'd2, 16'd2, 1'b0);
    send_beat(8'd4, 1'b0, acc_cyc);
    send_beat(8'd8, 1'b1, acc_cyc);
    go_idle();
    wait_idle();
    check_output("short_start_latency", 64'(last_start_cyc - acc_cyc), 64'd5);

    // Overflow: 1..8 without last, then 9 closes the second frame
    push_exp(48'h06_05_04_03_02_01, 3'd6, 16'd3, 1'b1);
    apply_stimulus(8'd1, 8, -1);
    go_idle();
    @(negedge clk);
    check_output("overflow_sticky", 64'(overflow), 64'd1);
    push_exp(48'hFF_FF_FF_09_08_07, 3'd3, 16'd4, 1'b1);
    send_beat(8'd9, 1'b1, acc_cyc);
    go_idle();
    wait_idle();

    // Continuous valid across two frames
    push_exp(48'h0F_0E_0D_0C_0B_0A, 3'd6, 16'd5, 1'b1);
    push_exp(48'h15_14_13_12_11_10, 3'd6, 16'd6, 1'b1);
    for (int i = 0; i < 12; i++)
      send_beat(8'h0A + 8'(i), (i == 5 || i == 11), acc_cyc);
    go_idle();
    wait_idle();
    check_output("start_spacing", 64'(last_start_cyc - prev_start_cyc), 64'd9);

    // Async reset after three beats
    apply_stimulus(8'h31, 3, -1);
    go_idle();
    #2 rst = 1'b1;
    #1;
    check_output("arst_frame_data", 64'(frame_data), 64'd0);
    check_output("arst_frame_len",  64'(frame_len),  64'd0);
    check_output("arst_start",      64'(start),      64'd0);
    check_output("arst_frame_cnt",  64'(frame_cnt),  64'd0);
    check_output("arst_overflow",   64'(overflow),   64'd0);
    check_output("arst_s_ready",    64'(s_if.s_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_exp(48'h26_25_24_23_22_21, 3'd6, 16'd1, 1'b0);
    apply_stimulus(8'h21, 6, 5);
    go_idle();
    wait_idle();

    // Single-element frame
    push_exp(48'hFF_FF_FF_FF_FF_00, 3'd1, 16'd2, 1'b0);
    send_beat(8'h00, 1'b1, acc_cyc);
    go_idle();
    wait_idle();
    check_output("single_start_latency", 64'(last_start_cyc - acc_cyc), 64'd6);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/sort_frame_packer.md
Name: sort_frame_packer

Overview:
- Upstream stage of the 6-element byte sorter.
- Accepts a valid/ready byte stream and packs it into fixed-size frames of N elements.
- Short frames are padded so that pads sort to the top. Each completed frame is presented as a parallel bus with a one-cycle start pulse.
- Enforces a minimum gap between start pulses so the sorter has time to register each result.

Parameters:
- N, 6: elements per frame (2..16).
- W, 8: element width in bits.
- PAD_VALUE, {W{1'b1}}: value written into unfilled slots of a short frame.
- GAP, 2: idle cycles after each start pulse before the next fill may begin (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  packer can accept a beat
- s_data  in  W  element value
- s_last  in  1  final element of the current frame
- frame_data  out  N*W  packed frame; slot k at bits [k*W +: W], slot 0 = first beat
- frame_len  out  $clog2(N+1)  number of real (non-pad) elements in frame_data
- start  out  1  one-cycle pulse; frame_data/frame_len valid this cycle and held until the next start
- frame_cnt  out  16  frames issued, wraps at 2^16
- overflow  out  1  sticky; set when s_last is not seen by the N-th beat

Behaviour:
- Reset (async): state=FILL, idx=0, s_ready=1, frame_data=0, frame_len=0, start=0, frame_cnt=0, overflow=0, gap counter=0.
- Beat accepted on a clk edge when s_valid && s_ready. The beat is written to slot idx and idx increments.
- FILL (s_ready=1):
  - Accepted beat with s_last=1 and idx+1==N -> ISSUE.
  - Accepted beat with s_last=1 and idx+1<N -> PAD.
  - Accepted beat with s_last=0 and idx+1==N -> set overflow, then ISSUE. The frame closes at N; subsequent beats start a new frame.
  - No beat -> stay in FILL.
- PAD (s_ready=0):
  - Each cycle write PAD_VALUE into slot idx and increment idx; one slot per cycle.
  - When idx reaches N-1 (last pad written) -> ISSUE.
  - Pad latency is N-len cycles.
- ISSUE (s_ready=0), exactly one cycle:
  - Register frame_data from the working buffer.
  - Register frame_len = count of real beats.
  - start=1; frame_cnt+1; idx=0.
  - If GAP==0 -> FILL, else -> WAIT.
- WAIT (s_ready=0):
  - Gap counter loaded with GAP-1 on entry; decrements each cycle.
  - At 0 -> FILL.
- Working buffer and output register are separate. frame_data holds the last issued frame stable while the next frame fills.
- Minimum latency from last accepted beat (full frame) to start: 1 cycle, with start asserted on the edge after ISSUE is entered, i.e. start is a registered output.
- Throughput for a full frame with GAP=2: N+1+2 cycles per frame.
- s_ready is combinational from state only (no dependence on s_valid).
- overflow clears only on rst.
- Reset mid-fill or mid-pad: the partial frame is discarded, no start is issued, and frame_data returns to 0.
- frame_len of a padded frame is the real beat count (1..N-1). For full or overflow frames it is N.

Decomposition:
- Shared package sort_pkg:
  - localparams SORT_N=6, SORT_W=8.
  - state enum {FILL, PAD, ISSUE, WAIT}.
  - PAD_VALUE default constant, shared with the downstream serializer so it can strip pads using frame_len.
- No sub-module; a single FSM plus an indexed buffer write.
- Top-level wiring: frame_data slots map to sorter in_data_0..5; start maps to sorter start.

Test Plan:
- Full frame: beats 5,3,9,1,7,2 (last on 6th), GAP=2.
  - start pulses once; frame_data slots = 5,3,9,1,7,2; frame_len=6; frame_cnt=1.
  - s_ready low for 3 cycles after the 6th beat.
- Short frame: beats 4,8 with last on the 2nd.
  - 4 pad cycles, then start; slots = 4,8,FF,FF,FF,FF; frame_len=2.
- Overflow: 8 beats 1..8, no last.
  - First frame 1..6 issued with overflow=1.
  - Beats 7,8 land in slots 0,1 of the next frame; overflow stays 1.
- Backpressure and gap:
  - s_valid held high continuously for two full frames -> exactly two start pulses, spaced 9 cycles apart.
  - No beat lost or duplicated; frame_cnt=2.
- Reset mid-operation: assert rst after 3 beats of a frame.
  - All outputs return to reset values immediately (async).
  - After release, a fresh 6-beat frame issues correctly with frame_cnt=1.
- Single-element frame: one beat 0x00 with last=1.
  - slots = 00,FF,FF,FF,FF,FF; frame_len=1; start is 6 cycles after acceptance.
